// File: rtl/led_pattern_gen.sv
// Parametrised LED pattern sequencer: a prescaler produces a step tick and the
// LED register advances by rotate, bounce, binary count or blink on each tick.
module led_pattern_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 25000000
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iEN,
    input  logic [1:0]       iMODE,
    output logic [WIDTH-1:0] oLED,
    output logic             oTICK
);

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_COUNT  = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [31:0] DIV_M1 = 32'(DIV - 1);

    mode_e            mode_q, mode_d;
    dir_e             dir_q, dir_d;
    logic [31:0]      presc_q, presc_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             tick_q, tick_d;
    logic             wrap;
    logic             reload;

    assign wrap   = (presc_q == DIV_M1);
    assign reload = (mode_e'(iMODE) != mode_q);

    // NOTE: every always_comb output takes a default first so no path leaves a latch.
    always_comb begin
        mode_d  = mode_q;
        dir_d   = dir_q;
        presc_d = presc_q;
        led_d   = led_q;
        tick_d  = 1'b0;

        if (reload) begin
            // Mode change wins over a due step: restart from the new mode's seed.
            mode_d  = mode_e'(iMODE);
            dir_d   = DIR_LEFT;
            presc_d = '0;
            unique case (mode_e'(iMODE))
                MODE_ROTATE: led_d = WIDTH'(1);
                MODE_BOUNCE: led_d = WIDTH'(1);
                MODE_COUNT:  led_d = '0;
                MODE_BLINK:  led_d = '1;
                default:     led_d = WIDTH'(1);
            endcase
        end else if (iEN) begin
            if (wrap) begin
                presc_d = '0;
                tick_d  = 1'b1;
                unique case (mode_q)
                    MODE_ROTATE: led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
                    MODE_BOUNCE: begin
                        if (dir_q == DIR_LEFT) begin
                            if (led_q[WIDTH-1]) begin
                                dir_d = DIR_RIGHT;
                                led_d = led_q >> 1;
                            end else begin
                                led_d = led_q << 1;
                            end
                        end else begin
                            if (led_q[0]) begin
                                dir_d = DIR_LEFT;
                                led_d = led_q << 1;
                            end else begin
                                led_d = led_q >> 1;
                            end
                        end
                    end
                    MODE_COUNT:  led_d = led_q + WIDTH'(1);
                    MODE_BLINK:  led_d = ~led_q;
                    default:     led_d = led_q;
                endcase
            end else begin
                presc_d = presc_q + 32'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            mode_q  <= MODE_ROTATE;
            dir_q   <= DIR_LEFT;
            presc_q <= '0;
            led_q   <= WIDTH'(1);
            tick_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            presc_q <= presc_d;
            led_q   <= led_d;
            tick_q  <= tick_d;
        end
    end

    assign oLED  = led_q;
    assign oTICK = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: three instances cover rotate/switch/pause
// (W8,DIV4), bounce/async reset (W8,DIV1) and the counter wrap (W4,DIV2).
module tb_led_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic       rst_a, en_a;
    logic [1:0] mode_a;
    logic [7:0] led_a;
    logic       tick_a;

    logic       rst_b, en_b;
    logic [1:0] mode_b;
    logic [7:0] led_b;
    logic       tick_b;

    logic       rst_c, en_c;
    logic [1:0] mode_c;
    logic [3:0] led_c;
    logic       tick_c;

    led_pattern_gen #(.WIDTH(8), .DIV(4)) dut_a (
        .iCLK(clk), .iRST(rst_a), .iEN(en_a), .iMODE(mode_a), .oLED(led_a), .oTICK(tick_a)
    );
    led_pattern_gen #(.WIDTH(8), .DIV(1)) dut_b (
        .iCLK(clk), .iRST(rst_b), .iEN(en_b), .iMODE(mode_b), .oLED(led_b), .oTICK(tick_b)
    );
    led_pattern_gen #(.WIDTH(4), .DIV(2)) dut_c (
        .iCLK(clk), .iRST(rst_c), .iEN(en_c), .iMODE(mode_c), .oLED(led_c), .oTICK(tick_c)
    );

    // One rising edge, then park on the falling edge where outputs are sampled.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
        mode_a = 2'b00; mode_b = 2'b01; mode_c = 2'b10;
        @(negedge clk);
        check_cnt++;
        if (led_a !== 8'h01) $display("FAIL reset_led_a: got %h want 01", led_a); else pass_cnt++;
        check_cnt++;
        if (tick_a !== 1'b0) $display("FAIL reset_tick_a: got %b want 0", tick_a); else pass_cnt++;
        check_cnt++;
        if (led_b !== 8'h01) $display("FAIL reset_led_b: got %h want 01", led_b); else pass_cnt++;
        check_cnt++;
        if (led_c !== 4'h1) $display("FAIL reset_led_c: got %h want 1", led_c); else pass_cnt++;
        check_cnt++;
        if (tick_c !== 1'b0) $display("FAIL reset_tick_c: got %b want 0", tick_c); else pass_cnt++;
    endtask

    task automatic test_rotate();
        logic [7:0] exp_led;
        logic       exp_tick;
        rst_a = 1'b1; mode_a = 2'b00; en_a = 1'b1;
        cyc();
        rst_a = 1'b0;
        exp_led = 8'h01;
        for (int k = 1; k <= 36; k++) begin
            cyc();
            exp_tick = (k % 4 == 0);
            if (exp_tick) exp_led = {exp_led[6:0], exp_led[7]};
            check_cnt++;
            if (led_a !== exp_led)
                $display("FAIL rotate_led edge %0d: got %h want %h", k, led_a, exp_led);
            else pass_cnt++;
            check_cnt++;
            if (tick_a !== exp_tick)
                $display("FAIL rotate_tick edge %0d: got %b want %b", k, tick_a, exp_tick);
            else pass_cnt++;
        end
    endtask

    task automatic test_mode_switch();
        logic [7:0] exp_led;
        logic       exp_tick;
        rst_a = 1'b1; mode_a = 2'b00; en_a = 1'b1;
        cyc();
        rst_a = 1'b0;
        repeat (14) cyc();
        check_cnt++;
        if (led_a !== 8'h08) $display("FAIL switch_pre_led: got %h want 08", led_a); else pass_cnt++;
        mode_a = 2'b11;
        cyc();
        check_cnt++;
        if (led_a !== 8'hFF) $display("FAIL switch_seed_led: got %h want ff", led_a); else pass_cnt++;
        check_cnt++;
        if (tick_a !== 1'b0) $display("FAIL switch_seed_tick: got %b want 0", tick_a); else pass_cnt++;
        exp_led = 8'hFF;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (k == 4) exp_led = 8'h00;
            if (k == 8) exp_led = 8'hFF;
            exp_tick = (k == 4) || (k == 8);
            check_cnt++;
            if (led_a !== exp_led || tick_a !== exp_tick)
                $display("FAIL blink edge %0d: got %h/%b want %h/%b", k, led_a, tick_a, exp_led, exp_tick);
            else pass_cnt++;
        end
    endtask

    task automatic test_pause();
        rst_a = 1'b1; mode_a = 2'b00; en_a = 1'b1;
        cyc();
        rst_a = 1'b0;
        repeat (9) cyc();
        en_a = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            check_cnt++;
            if (led_a !== 8'h04 || tick_a !== 1'b0)
                $display("FAIL pause_hold cycle %0d: got %h/%b want 04/0", k, led_a, tick_a);
            else pass_cnt++;
        end
        en_a = 1'b1;
        cyc();
        check_cnt++;
        if (led_a !== 8'h04 || tick_a !== 1'b0)
            $display("FAIL resume_1: got %h/%b want 04/0", led_a, tick_a);
        else pass_cnt++;
        cyc();
        check_cnt++;
        if (led_a !== 8'h04 || tick_a !== 1'b0)
            $display("FAIL resume_2: got %h/%b want 04/0", led_a, tick_a);
        else pass_cnt++;
        cyc();
        check_cnt++;
        if (led_a !== 8'h08 || tick_a !== 1'b1)
            $display("FAIL resume_3: got %h/%b want 08/1", led_a, tick_a);
        else pass_cnt++;
    endtask

    task automatic test_bounce();
        logic [7:0] bounce_exp [0:14];
        bounce_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                       8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        rst_b = 1'b1; mode_b = 2'b01; en_b = 1'b1;
        cyc();
        rst_b = 1'b0;
        cyc();
        check_cnt++;
        if (led_b !== 8'h01 || tick_b !== 1'b0)
            $display("FAIL bounce_seed: got %h/%b want 01/0", led_b, tick_b);
        else pass_cnt++;
        for (int i = 0; i < 15; i++) begin
            cyc();
            check_cnt++;
            if (led_b !== bounce_exp[i] || tick_b !== 1'b1)
                $display("FAIL bounce step %0d: got %h/%b want %h/1", i + 1, led_b, tick_b, bounce_exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        rst_b = 1'b1; mode_b = 2'b01; en_b = 1'b1;
        cyc();
        rst_b = 1'b0;
        cyc();
        repeat (9) cyc();
        check_cnt++;
        if (led_b !== 8'h20) $display("FAIL areset_pre: got %h want 20", led_b); else pass_cnt++;
        #1 rst_b = 1'b1;
        #1;
        check_cnt++;
        if (led_b !== 8'h01 || tick_b !== 1'b0)
            $display("FAIL areset_immediate: got %h/%b want 01/0", led_b, tick_b);
        else pass_cnt++;
        @(negedge clk);
        rst_b = 1'b0;
        cyc();
        check_cnt++;
        if (led_b !== 8'h01 || tick_b !== 1'b0)
            $display("FAIL areset_reload: got %h/%b want 01/0", led_b, tick_b);
        else pass_cnt++;
        cyc();
        check_cnt++;
        if (led_b !== 8'h02 || tick_b !== 1'b1)
            $display("FAIL areset_first_step: got %h/%b want 02/1", led_b, tick_b);
        else pass_cnt++;
    endtask

    task automatic test_counter();
        logic [3:0] exp_led;
        rst_c = 1'b1; mode_c = 2'b10; en_c = 1'b1;
        cyc();
        rst_c = 1'b0;
        cyc();
        check_cnt++;
        if (led_c !== 4'h0 || tick_c !== 1'b0)
            $display("FAIL count_seed: got %h/%b want 0/0", led_c, tick_c);
        else pass_cnt++;
        for (int n = 1; n <= 17; n++) begin
            cyc();
            exp_led = 4'(n - 1);
            check_cnt++;
            if (led_c !== exp_led || tick_c !== 1'b0)
                $display("FAIL count_idle n=%0d: got %h/%b want %h/0", n, led_c, tick_c, exp_led);
            else pass_cnt++;
            cyc();
            exp_led = 4'(n);
            check_cnt++;
            if (led_c !== exp_led || tick_c !== 1'b1)
                $display("FAIL count_step n=%0d: got %h/%b want %h/1", n, led_c, tick_c, exp_led);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_mode_switch();
        test_pause();
        test_bounce();
        test_async_reset();
        test_counter();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
